// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU functions, condition codes,
// status codes and the pipeline-register bubble values.
package y86_pkg;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_CMOVXX = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_fun_e;

    typedef enum logic [3:0] {
        C_YES = 4'd0,
        C_LE  = 4'd1,
        C_L   = 4'd2,
        C_E   = 4'd3,
        C_NE  = 4'd4,
        C_GE  = 4'd5,
        C_G   = 4'd6
    } cond_e;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    localparam logic [3:0] RNONE        = 4'hF;
    localparam logic [2:0] BUBBLE_STAT  = STAT_AOK;
    localparam logic [3:0] BUBBLE_ICODE = I_NOP;
    localparam logic [3:0] BUBBLE_IFUN  = 4'h0;
    localparam logic [2:0] CC_RESET     = 3'b100;

    // cc is packed {ZF,SF,OF}
    function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] cc);
        logic zf, sf, of;
        {zf, sf, of} = cc;
        case (ifun)
            C_YES:   cond_eval = 1'b1;
            C_LE:    cond_eval = (sf ^ of) | zf;
            C_L:     cond_eval = sf ^ of;
            C_E:     cond_eval = zf;
            C_NE:    cond_eval = !zf;
            C_GE:    cond_eval = !(sf ^ of);
            C_G:     cond_eval = !(sf ^ of) & !zf;
            default: cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/y86_alu.sv
// Combinational Y86-64 ALU; sub computes b - a. Flags are {ZF,SF,OF}.
module y86_alu
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0] alu_a_i,
    input  logic [W-1:0] alu_b_i,
    input  logic [1:0]   fun_i,
    output logic [W-1:0] result_o,
    output logic [2:0]   flags_o
);

    logic [W-1:0] res;
    logic         of;

    always_comb begin
        res = '0;
        of  = 1'b0;
        case (fun_i)
            ALU_ADD: begin
                res = alu_b_i + alu_a_i;
                of  = (alu_a_i[W-1] == alu_b_i[W-1]) && (res[W-1] != alu_a_i[W-1]);
            end
            ALU_SUB: begin
                res = alu_b_i - alu_a_i;
                of  = (alu_a_i[W-1] != alu_b_i[W-1]) && (res[W-1] != alu_b_i[W-1]);
            end
            ALU_AND: res = alu_b_i & alu_a_i;
            default: res = alu_b_i ^ alu_a_i;
        endcase
    end

    assign result_o = res;
    assign flags_o  = {(res == '0), res[W-1], of};

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: E pipeline register, ALU, condition codes and the
// M pipeline register, with combinational forwarding outputs.
module execute_stage
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   d_stat,
    input  logic [3:0]   d_iCode,
    input  logic [3:0]   d_iFun,
    input  logic [W-1:0] d_valC,
    input  logic [W-1:0] d_valA,
    input  logic [W-1:0] d_valB,
    input  logic [3:0]   d_dstE,
    input  logic [3:0]   d_dstM,
    input  logic         e_stall,
    input  logic         e_bubble,
    input  logic         m_bubble,
    input  logic         m_exc,
    input  logic         w_exc,
    output logic [W-1:0] e_valE,
    output logic [3:0]   e_dstE,
    output logic         e_Cnd,
    output logic [2:0]   M_stat,
    output logic [3:0]   M_iCode,
    output logic         M_Cnd,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM,
    output logic [2:0]   cc_out
);

    localparam logic [W-1:0] EIGHT = W'(8);

    logic [2:0]   E_stat_q,  E_stat_d;
    logic [3:0]   E_iCode_q, E_iCode_d;
    logic [3:0]   E_iFun_q,  E_iFun_d;
    logic [W-1:0] E_valC_q,  E_valC_d;
    logic [W-1:0] E_valA_q,  E_valA_d;
    logic [W-1:0] E_valB_q,  E_valB_d;
    logic [3:0]   E_dstE_q,  E_dstE_d;
    logic [3:0]   E_dstM_q,  E_dstM_d;

    logic [2:0]   M_stat_q,  M_stat_d;
    logic [3:0]   M_iCode_q, M_iCode_d;
    logic         M_Cnd_q,   M_Cnd_d;
    logic [W-1:0] M_valE_q,  M_valE_d;
    logic [W-1:0] M_valA_q,  M_valA_d;
    logic [3:0]   M_dstE_q,  M_dstE_d;
    logic [3:0]   M_dstM_q,  M_dstM_d;

    logic [2:0]   cc_q, cc_d;
    logic [W-1:0] alu_a, alu_b, alu_res;
    logic [1:0]   alu_fun;
    logic [2:0]   alu_flags;
    logic         cnd;

    always_comb begin
        E_stat_d  = E_stat_q;
        E_iCode_d = E_iCode_q;
        E_iFun_d  = E_iFun_q;
        E_valC_d  = E_valC_q;
        E_valA_d  = E_valA_q;
        E_valB_d  = E_valB_q;
        E_dstE_d  = E_dstE_q;
        E_dstM_d  = E_dstM_q;
        if (e_bubble) begin
            E_stat_d  = BUBBLE_STAT;
            E_iCode_d = BUBBLE_ICODE;
            E_iFun_d  = BUBBLE_IFUN;
            E_valC_d  = '0;
            E_valA_d  = '0;
            E_valB_d  = '0;
            E_dstE_d  = RNONE;
            E_dstM_d  = RNONE;
        end else if (!e_stall) begin
            E_stat_d  = d_stat;
            E_iCode_d = d_iCode;
            E_iFun_d  = d_iFun;
            E_valC_d  = d_valC;
            E_valA_d  = d_valA;
            E_valB_d  = d_valB;
            E_dstE_d  = d_dstE;
            E_dstM_d  = d_dstM;
        end
    end

    always_comb begin
        alu_a = '0;
        alu_b = '0;
        case (E_iCode_q)
            I_OPQ, I_CMOVXX:            alu_a = E_valA_q;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC_q;
            I_CALL, I_PUSHQ:            alu_a = '0 - EIGHT;
            I_RET, I_POPQ:              alu_a = EIGHT;
            default:                    alu_a = '0;
        endcase
        case (E_iCode_q)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = E_valB_q;
            default:                                                  alu_b = '0;
        endcase
    end

    assign alu_fun = (E_iCode_q == I_OPQ) ? E_iFun_q[1:0] : ALU_ADD;

    y86_alu #(.W(W)) u_alu (
        .alu_a_i  (alu_a),
        .alu_b_i  (alu_b),
        .fun_i    (alu_fun),
        .result_o (alu_res),
        .flags_o  (alu_flags)
    );

    // Cnd reads the pre-update CC so a following jXX/cmov sees flags written at this edge.
    assign cnd    = ((E_iCode_q == I_JXX) || (E_iCode_q == I_CMOVXX)) ? cond_eval(E_iFun_q, cc_q) : 1'b0;
    assign e_Cnd  = cnd;
    assign e_valE = alu_res;
    assign e_dstE = ((E_iCode_q == I_CMOVXX) && !cnd) ? RNONE : E_dstE_q;

    always_comb begin
        cc_d = cc_q;
        if ((E_iCode_q == I_OPQ) && !m_exc && !w_exc) cc_d = alu_flags;
    end

    always_comb begin
        M_stat_d  = E_stat_q;
        M_iCode_d = E_iCode_q;
        M_Cnd_d   = cnd;
        M_valE_d  = alu_res;
        M_valA_d  = E_valA_q;
        M_dstE_d  = e_dstE;
        M_dstM_d  = E_dstM_q;
        if (m_bubble) begin
            M_stat_d  = BUBBLE_STAT;
            M_iCode_d = BUBBLE_ICODE;
            M_Cnd_d   = 1'b0;
            M_valE_d  = '0;
            M_valA_d  = '0;
            M_dstE_d  = RNONE;
            M_dstM_d  = RNONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            E_stat_q  <= BUBBLE_STAT;
            E_iCode_q <= BUBBLE_ICODE;
            E_iFun_q  <= BUBBLE_IFUN;
            E_valC_q  <= '0;
            E_valA_q  <= '0;
            E_valB_q  <= '0;
            E_dstE_q  <= RNONE;
            E_dstM_q  <= RNONE;
            M_stat_q  <= BUBBLE_STAT;
            M_iCode_q <= BUBBLE_ICODE;
            M_Cnd_q   <= 1'b0;
            M_valE_q  <= '0;
            M_valA_q  <= '0;
            M_dstE_q  <= RNONE;
            M_dstM_q  <= RNONE;
            cc_q      <= CC_RESET;
        end else begin
            E_stat_q  <= E_stat_d;
            E_iCode_q <= E_iCode_d;
            E_iFun_q  <= E_iFun_d;
            E_valC_q  <= E_valC_d;
            E_valA_q  <= E_valA_d;
            E_valB_q  <= E_valB_d;
            E_dstE_q  <= E_dstE_d;
            E_dstM_q  <= E_dstM_d;
            M_stat_q  <= M_stat_d;
            M_iCode_q <= M_iCode_d;
            M_Cnd_q   <= M_Cnd_d;
            M_valE_q  <= M_valE_d;
            M_valA_q  <= M_valA_d;
            M_dstE_q  <= M_dstE_d;
            M_dstM_q  <= M_dstM_d;
            cc_q      <= cc_d;
        end
    end

    assign M_stat  = M_stat_q;
    assign M_iCode = M_iCode_q;
    assign M_Cnd   = M_Cnd_q;
    assign M_valE  = M_valE_q;
    assign M_valA  = M_valA_q;
    assign M_dstE  = M_dstE_q;
    assign M_dstM  = M_dstM_q;
    assign cc_out  = cc_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboarded bench for execute_stage: expected M-register contents are queued
// as each instruction is driven and compared when it reaches M.
module tb_execute_stage;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } m_rec_t;

    typedef struct {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        m_rec_t      exp;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  d_stat;
    logic [3:0]  d_iCode, d_iFun, d_dstE, d_dstM;
    logic [63:0] d_valC, d_valA, d_valB;
    logic        e_stall, e_bubble, m_bubble, m_exc, w_exc;
    logic [63:0] e_valE, M_valE, M_valA;
    logic [3:0]  e_dstE, M_iCode, M_dstE, M_dstM;
    logic        e_Cnd, M_Cnd;
    logic [2:0]  M_stat, cc_out;

    m_rec_t obs, exp;
    m_rec_t exp_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    execute_stage #(.W(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d_stat   (d_stat),
        .d_iCode  (d_iCode),
        .d_iFun   (d_iFun),
        .d_valC   (d_valC),
        .d_valA   (d_valA),
        .d_valB   (d_valB),
        .d_dstE   (d_dstE),
        .d_dstM   (d_dstM),
        .e_stall  (e_stall),
        .e_bubble (e_bubble),
        .m_bubble (m_bubble),
        .m_exc    (m_exc),
        .w_exc    (w_exc),
        .e_valE   (e_valE),
        .e_dstE   (e_dstE),
        .e_Cnd    (e_Cnd),
        .M_stat   (M_stat),
        .M_iCode  (M_iCode),
        .M_Cnd    (M_Cnd),
        .M_valE   (M_valE),
        .M_valA   (M_valA),
        .M_dstE   (M_dstE),
        .M_dstM   (M_dstM),
        .cc_out   (cc_out)
    );

    always #5 clk = ~clk;

    assign obs = '{M_stat, M_iCode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM};

    function automatic m_rec_t mk(input logic [2:0] st, input logic [3:0] ic, input logic c,
                                  input logic [63:0] ve, input logic [63:0] va,
                                  input logic [3:0] de, input logic [3:0] dm);
        mk = '{st, ic, c, ve, va, de, dm};
    endfunction

    function automatic m_rec_t bubble_rec();
        bubble_rec = mk(3'd1, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] c, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] de, input logic [3:0] dm);
        d_stat = st; d_iCode = ic; d_iFun = fn;
        d_valC = c;  d_valA = a;   d_valB = b;
        d_dstE = de; d_dstM = dm;
    endtask

    task automatic drive_nop();
        drive(3'd1, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(3'd1, 4'h6, 4'h1, 64'h0, 64'h5, 64'h3, 4'h2, 4'hF);
        exp_q.push_back(bubble_rec());
        tick();
        tick();
        exp = exp_q.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL reset_m: got %h expected %h", obs, exp);
        end
        n_checks++;
        if (cc_out !== 3'b100) begin
            n_fail++; $display("FAIL reset_cc: got %b expected 100", cc_out);
        end
        drive_nop();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_opq_sub();
        drive(3'd1, 4'h6, 4'h1, 64'h0, 64'h5, 64'h3, 4'h2, 4'hF);
        exp_q.push_back(mk(3'd1, 4'h6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h5, 4'h2, 4'hF));
        tick();
        n_checks++;
        if (e_valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            n_fail++; $display("FAIL sub_e_valE: got %h expected fffffffffffffffe", e_valE);
        end
        drive_nop();
        tick();
        exp = exp_q.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL sub_m: got %h expected %h", obs, exp);
        end
        n_checks++;
        if (cc_out !== 3'b010) begin
            n_fail++; $display("FAIL sub_cc: got %b expected 010", cc_out);
        end
        // 1+1 would give flags 000 if the suppressed update leaked through
        w_exc = 1'b1;
        drive(3'd1, 4'h6, 4'h0, 64'h0, 64'h1, 64'h1, 4'h3, 4'hF);
        exp_q.push_back(mk(3'd1, 4'h6, 1'b0, 64'h2, 64'h1, 4'h3, 4'hF));
        tick();
        drive_nop();
        tick();
        w_exc = 1'b0;
        exp = exp_q.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL wexc_m: got %h expected %h", obs, exp);
        end
        n_checks++;
        if (cc_out !== 3'b010) begin
            n_fail++; $display("FAIL wexc_cc: got %b expected 010", cc_out);
        end
        m_exc = 1'b1;
        drive(3'd1, 4'h6, 4'h3, 64'h0, 64'h1, 64'h1, 4'h3, 4'hF);
        exp_q.push_back(mk(3'd1, 4'h6, 1'b0, 64'h0, 64'h1, 4'h3, 4'hF));
        tick();
        drive_nop();
        tick();
        m_exc = 1'b0;
        exp = exp_q.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL mexc_m: got %h expected %h", obs, exp);
        end
        n_checks++;
        if (cc_out !== 3'b010) begin
            n_fail++; $display("FAIL mexc_cc: got %b expected 010", cc_out);
        end
    endtask

    task automatic test_overflow_jxx();
        drive(3'd1, 4'h6, 4'h0, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'h4, 4'hF);
        exp_q.push_back(mk(3'd1, 4'h6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h7FFF_FFFF_FFFF_FFFF, 4'h4, 4'hF));
        tick();
        drive(3'd1, 4'h7, 4'h2, 64'h40, 64'h11, 64'h0, 4'hF, 4'hF);
        exp_q.push_back(mk(3'd1, 4'h7, 1'b0, 64'h0, 64'h11, 4'hF, 4'hF));
        tick();
        n_checks++;
        if (cc_out !== 3'b011) begin
            n_fail++; $display("FAIL add_ovf_cc: got %b expected 011", cc_out);
        end
        n_checks++;
        if (e_Cnd !== 1'b0) begin
            n_fail++; $display("FAIL jl_cnd: got %b expected 0", e_Cnd);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL add_ovf_m: got %h expected %h", obs, exp);
        end
        drive(3'd1, 4'h7, 4'h1, 64'h40, 64'h22, 64'h0, 4'hF, 4'hF);
        exp_q.push_back(mk(3'd1, 4'h7, 1'b0, 64'h0, 64'h22, 4'hF, 4'hF));
        tick();
        n_checks++;
        if (e_Cnd !== 1'b0) begin
            n_fail++; $display("FAIL jle_cnd: got %b expected 0", e_Cnd);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL jl_m: got %h expected %h", obs, exp);
        end
        drive(3'd1, 4'h7, 4'h5, 64'h40, 64'h33, 64'h0, 4'hF, 4'hF);
        exp_q.push_back(mk(3'd1, 4'h7, 1'b1, 64'h0, 64'h33, 4'hF, 4'hF));
        tick();
        n_checks++;
        if (e_Cnd !== 1'b1) begin
            n_fail++; $display("FAIL jge_cnd: got %b expected 1", e_Cnd);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL jle_m: got %h expected %h", obs, exp);
        end
        drive_nop();
        tick();
        exp = exp_q.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL jge_m: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_cmov();
        drive(3'd1, 4'h2, 4'h3, 64'h0, 64'hABC, 64'h999, 4'h2, 4'hF);
        exp_q.push_back(mk(3'd1, 4'h2, 1'b0, 64'hABC, 64'hABC, 4'hF, 4'hF));
        tick();
        n_checks++;
        if (e_dstE !== 4'hF) begin
            n_fail++; $display("FAIL cmove_nz_e_dstE: got %h expected f", e_dstE);
        end
        drive_nop();
        tick();
        exp = exp_q.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL cmove_nz_m: got %h expected %h", obs, exp);
        end
        drive(3'd1, 4'h6, 4'h3, 64'h0, 64'h7, 64'h7, 4'h5, 4'hF);
        exp_q.push_back(mk(3'd1, 4'h6, 1'b0, 64'h0, 64'h7, 4'h5, 4'hF));
        tick();
        drive(3'd1, 4'h2, 4'h3, 64'h0, 64'hDEF, 64'h0, 4'h2, 4'hF);
        exp_q.push_back(mk(3'd1, 4'h2, 1'b1, 64'hDEF, 64'hDEF, 4'h2, 4'hF));
        tick();
        n_checks++;
        if (cc_out !== 3'b100) begin
            n_fail++; $display("FAIL xor_zero_cc: got %b expected 100", cc_out);
        end
        n_checks++;
        if (e_dstE !== 4'h2) begin
            n_fail++; $display("FAIL cmove_z_e_dstE: got %h expected 2", e_dstE);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL xor_zero_m: got %h expected %h", obs, exp);
        end
        drive_nop();
        tick();
        exp = exp_q.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL cmove_z_m: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[7];
        s[0] = '{3'd1, 4'hA, 4'h0, 64'h0,  64'h77,   64'h100, 4'h4, 4'hF, mk(3'd1, 4'hA, 1'b0, 64'hF8,  64'h77,   4'h4, 4'hF)};
        s[1] = '{3'd1, 4'hB, 4'h0, 64'h0,  64'h100,  64'h100, 4'h4, 4'h3, mk(3'd1, 4'hB, 1'b0, 64'h108, 64'h100,  4'h4, 4'h3)};
        s[2] = '{3'd1, 4'h4, 4'h0, 64'h10, 64'h1234, 64'h20,  4'hF, 4'hF, mk(3'd1, 4'h4, 1'b0, 64'h30,  64'h1234, 4'hF, 4'hF)};
        s[3] = '{3'd1, 4'h8, 4'h0, 64'h0,  64'h0,    64'h200, 4'h4, 4'hF, mk(3'd1, 4'h8, 1'b0, 64'h1F8, 64'h0,    4'h4, 4'hF)};
        s[4] = '{3'd1, 4'h9, 4'h0, 64'h0,  64'h1F8,  64'h1F8, 4'h4, 4'hF, mk(3'd1, 4'h9, 1'b0, 64'h200, 64'h1F8,  4'h4, 4'hF)};
        s[5] = '{3'd1, 4'h3, 4'h0, 64'h5A, 64'h0,    64'h999, 4'h6, 4'hF, mk(3'd1, 4'h3, 1'b0, 64'h5A,  64'h0,    4'h6, 4'hF)};
        s[6] = '{3'd2, 4'h0, 4'h0, 64'h0,  64'h44,   64'h55,  4'hF, 4'hF, mk(3'd2, 4'h0, 1'b0, 64'h0,   64'h44,   4'hF, 4'hF)};
        for (int i = 0; i <= 7; i++) begin
            if (i < 7) begin
                drive(s[i].stat, s[i].icode, s[i].ifun, s[i].valC, s[i].valA, s[i].valB, s[i].dstE, s[i].dstM);
                exp_q.push_back(s[i].exp);
            end else begin
                drive_nop();
            end
            tick();
            if (i > 0) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (obs !== exp) begin
                    n_fail++; $display("FAIL b2b_m[%0d]: got %h expected %h", i - 1, obs, exp);
                end
            end
        end
        tick();
    endtask

    task automatic test_stall();
        m_rec_t irm;
        irm = mk(3'd1, 4'h3, 1'b0, 64'h55, 64'h0, 4'h3, 4'hF);
        drive(3'd1, 4'h3, 4'h0, 64'h55, 64'h0, 64'h0, 4'h3, 4'hF);
        tick();
        e_stall = 1'b1;
        drive(3'd1, 4'hA, 4'h0, 64'h0, 64'h0, 64'h500, 4'h4, 4'hF);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                e_stall = 1'b0;
                drive_nop();
            end
            exp_q.push_back(irm);
            tick();
            exp = exp_q.pop_front();
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL stall_m[%0d]: got %h expected %h", i, obs, exp);
            end
        end
        exp_q.push_back(bubble_rec());
        tick();
        exp = exp_q.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL stall_release_m: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_bubble_stall();
        drive(3'd1, 4'h3, 4'h0, 64'h66, 64'h0, 64'h0, 4'h6, 4'hF);
        tick();
        e_stall  = 1'b1;
        e_bubble = 1'b1;
        drive(3'd1, 4'hA, 4'h0, 64'h0, 64'h0, 64'h500, 4'h4, 4'hF);
        exp_q.push_back(mk(3'd1, 4'h3, 1'b0, 64'h66, 64'h0, 4'h6, 4'hF));
        tick();
        e_stall  = 1'b0;
        e_bubble = 1'b0;
        n_checks++;
        if ({e_valE, e_dstE} !== {64'h0, 4'hF}) begin
            n_fail++; $display("FAIL bubble_e: got %h/%h expected 0/f", e_valE, e_dstE);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL bubble_prev_m: got %h expected %h", obs, exp);
        end
        drive_nop();
        exp_q.push_back(bubble_rec());
        tick();
        exp = exp_q.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL bubble_m: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_m_bubble();
        drive(3'd1, 4'h3, 4'h0, 64'h77, 64'h9, 64'h0, 4'h7, 4'hF);
        tick();
        m_bubble = 1'b1;
        drive_nop();
        exp_q.push_back(bubble_rec());
        tick();
        m_bubble = 1'b0;
        exp = exp_q.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL m_bubble_m: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_reset_midstream();
        drive(3'd1, 4'h6, 4'h0, 64'h0, 64'h1, 64'h1, 4'h3, 4'hF);
        tick();
        rst_n = 1'b0;
        drive_nop();
        exp_q.push_back(bubble_rec());
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (cc_out !== 3'b100) begin
            n_fail++; $display("FAIL midreset_cc: got %b expected 100", cc_out);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL midreset_m: got %h expected %h", obs, exp);
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        e_stall = 1'b0; e_bubble = 1'b0; m_bubble = 1'b0;
        m_exc = 1'b0;   w_exc = 1'b0;
        drive_nop();
        test_reset();
        test_opq_sub();
        test_overflow_jxx();
        test_cmov();
        test_back_to_back();
        test_stall();
        test_bubble_stall();
        test_m_bubble();
        test_reset_midstream();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
